// File: rtl/chip8_keypad_pkg.sv
// rtl/chip8_keypad_pkg.sv - shared key map and state encodings for the CHIP-8 keypad scanner
package chip8_keypad_pkg;

    // Hex value of the key at matrix position [row][col], COSMAC layout
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hC},
        '{4'h4, 4'h5, 4'h6, 4'hD},
        '{4'h7, 4'h8, 4'h9, 4'hE},
        '{4'hA, 4'h0, 4'hB, 4'hF}
    };

    typedef enum logic [1:0] {
        SC_COL0,
        SC_COL1,
        SC_COL2,
        SC_COL3
    } scan_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ARMED,
        W_HOLD
    } wait_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - per-key frame-based debounce counter and stable bit
module keypad_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_strobe,
    input  logic raw,
    output logic stable,
    output logic flip
);

    localparam int CW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES);

    logic [CW-1:0] cnt;

    // High in the strobe cycle whose clock edge toggles stable
    assign flip = frame_strobe && (raw != stable) && (cnt == CW'(DEBOUNCE_FRAMES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (frame_strobe) begin
            if (raw == stable) begin
                cnt <= '0;
            end else if (flip) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 hex keypad scan, debounce and FX0A wait handshake (option: KEYPAD_GHOST_REJECT_EN)
module keypad_scanner
    import chip8_keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [15:0] keys,
    output logic        any_key,
    input  logic        wait_req,
    output logic        wait_valid,
    output logic [3:0]  wait_key
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    logic [3:0]       row_s1, row_s2;
    scan_state_t      scan_state, scan_next;
    logic [SW-1:0]    settle_cnt, settle_next;
    logic [1:0]       col_idx;
    logic             active;
    logic             sample;
    logic             frame_strobe;
    logic             apply_strobe;
    logic [3:0][3:0]  raw;
    logic [15:0]      raw_hex;
    logic [15:0]      flip;
    logic [15:0]      released;
    logic [3:0]       rel_low;
    wait_state_t      w_state, w_next;
    logic             valid_next;
    logic [3:0]       key_next;

    assign col_idx = scan_state;

    // active holds the scan off for the cycle of reset release so col 0 gets a full slot
    assign col_n = active ? ~(4'b0001 << col_idx) : 4'b1111;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1       <= 4'b1111;
            row_s2       <= 4'b1111;
            scan_state   <= SC_COL0;
            settle_cnt   <= '0;
            active       <= 1'b0;
            frame_strobe <= 1'b0;
            raw          <= '0;
        end else begin
            row_s1       <= row_n;
            row_s2       <= row_s1;
            active       <= 1'b1;
            scan_state   <= scan_next;
            settle_cnt   <= settle_next;
            frame_strobe <= sample && (scan_state == SC_COL3);
            if (sample) begin
                for (int r = 0; r < 4; r++) begin
                    raw[r][col_idx] <= ~row_s2[r];
                end
            end
        end
    end

    always_comb begin
        scan_next   = scan_state;
        settle_next = settle_cnt;
        sample      = active && (settle_cnt == SW'(SETTLE_CYCLES));
        if (active) begin
            if (sample) begin
                settle_next = '0;
                case (scan_state)
                    SC_COL0: scan_next = SC_COL1;
                    SC_COL1: scan_next = SC_COL2;
                    SC_COL2: scan_next = SC_COL3;
                    SC_COL3: scan_next = SC_COL0;
                    default: scan_next = SC_COL0;
                endcase
            end else begin
                settle_next = settle_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        raw_hex = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                raw_hex[KEY_MAP[r][c]] = raw[r][c];
            end
        end
    end

`ifdef KEYPAD_GHOST_REJECT_EN
    // More than two pressed keys may include phantom keys; drop the whole frame
    assign apply_strobe = frame_strobe && ($countones(raw) <= 2);
`else
    assign apply_strobe = frame_strobe;
`endif

    for (genvar k = 0; k < 16; k++) begin : g_key
        keypad_debounce #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_debounce (
            .clk         (clk),
            .rst_n       (rst_n),
            .frame_strobe(apply_strobe),
            .raw         (raw_hex[k]),
            .stable      (keys[k]),
            .flip        (flip[k])
        );
    end

    assign released = flip & keys;

    always_comb begin
        rel_low = 4'h0;
        for (int k = 15; k >= 0; k--) begin
            if (released[k]) begin
                rel_low = 4'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            wait_valid <= 1'b0;
            wait_key   <= 4'h0;
            any_key    <= 1'b0;
        end else begin
            w_state    <= w_next;
            wait_valid <= valid_next;
            wait_key   <= key_next;
            any_key    <= |(keys ^ flip);
        end
    end

    always_comb begin
        w_next     = w_state;
        valid_next = 1'b0;
        key_next   = wait_key;
        case (w_state)
            W_IDLE: begin
                if (wait_req) begin
                    w_next = W_ARMED;
                end
            end
            W_ARMED: begin
                if (!wait_req) begin
                    w_next = W_IDLE;
                end else if (|released) begin
                    valid_next = 1'b1;
                    key_next   = rel_low;
                    w_next     = W_HOLD;
                end
            end
            W_HOLD: begin
                if (!wait_req) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner with a frame-level reference model
module tb_keypad_scanner;

    localparam int DEB = 3;

`ifdef KEYPAD_GHOST_REJECT_EN
    localparam bit GHOST = 1'b1;
    localparam logic [15:0] GK = 16'h0000;
`else
    localparam bit GHOST = 1'b0;
    localparam logic [15:0] GK = 16'h0016;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys;
    logic        any_key;
    logic        wait_req;
    logic        wait_valid;
    logic [3:0]  wait_key;

    logic [15:0] pressed;

    int bmap [4][4] = '{'{1, 2, 3, 12}, '{4, 5, 6, 13}, '{7, 8, 9, 14}, '{10, 0, 11, 15}};

    int errors = 0;
    int checks = 0;

    logic [15:0] m_keys;
    int          m_cnt [16];
    bit          m_served;
    bit          m_pulse;
    logic [3:0]  m_wkey;

    logic [15:0] seen_keys;
    logic        seen_valid;
    logic [3:0]  seen_wkey;

    typedef struct {
        logic [15:0] press;
        logic        wr;
        logic [15:0] exp_keys;
        logic        exp_valid;
        logic [3:0]  exp_wkey;
    } vec_t;

    vec_t tv [38];

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_FRAMES(DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .keys      (keys),
        .any_key   (any_key),
        .wait_req  (wait_req),
        .wait_valid(wait_valid),
        .wait_key  (wait_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal diode matrix: a row reads low when a pressed key sits on a driven column
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_n[c] && pressed[bmap[r][c]]) row_n[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_keys = '0;
        for (int k = 0; k < 16; k++) m_cnt[k] = 0;
        m_served = 1'b0;
        m_pulse = 1'b0;
        m_wkey = 4'h0;
    endtask

    task automatic model_frame(input logic [15:0] p, input logic wr);
        logic [15:0] rel;
        rel = '0;
        m_pulse = 1'b0;
        if (!(GHOST && $countones(p) > 2)) begin
            for (int k = 0; k < 16; k++) begin
                if (p[k] != m_keys[k]) begin
                    m_cnt[k]++;
                    if (m_cnt[k] == DEB) begin
                        if (m_keys[k]) rel[k] = 1'b1;
                        m_keys[k] = ~m_keys[k];
                        m_cnt[k] = 0;
                    end
                end else begin
                    m_cnt[k] = 0;
                end
            end
        end
        if (!wr) begin
            m_served = 1'b0;
        end else if (!m_served && rel != 0) begin
            m_pulse = 1'b1;
            m_served = 1'b1;
            for (int k = 15; k >= 0; k--) if (rel[k]) m_wkey = 4'(k);
        end
    endtask

    // Called just after the first edge of a frame; ends just after the first edge of the next
    task automatic run_frame(input logic [15:0] p, input logic wr);
        logic [3:0] exp_col;
        pressed = p;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            exp_col = ~(4'b0001 << ((i % 20) / 5));
            chk("col_n", {28'd0, col_n}, {28'd0, exp_col});
            chk("keys", {16'd0, keys}, {16'd0, m_keys});
            chk("any_key", {31'd0, any_key}, {31'd0, |m_keys});
            chk("wait_valid", {31'd0, wait_valid}, {31'd0, (i == 1) && m_pulse});
            chk("wait_key", {28'd0, wait_key}, {28'd0, m_wkey});
            if (i == 1) begin
                seen_keys = keys;
                seen_valid = wait_valid;
                seen_wkey = wait_key;
                wait_req = wr;
            end
        end
        model_frame(p, wr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_col_n"}, {28'd0, col_n}, 32'hF);
        chk({tag, "_keys"}, {16'd0, keys}, 32'h0);
        chk({tag, "_any_key"}, {31'd0, any_key}, 32'h0);
        chk({tag, "_wait_valid"}, {31'd0, wait_valid}, 32'h0);
        chk({tag, "_wait_key"}, {28'd0, wait_key}, 32'h0);
    endtask

    initial begin
        logic [15:0] rp;
        logic        rw;

        tv[0]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[1]  = '{16'h0040, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[2]  = '{16'h0040, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[3]  = '{16'h0040, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[4]  = '{16'h0040, 1'b0, 16'h0040, 1'b0, 4'h0};
        tv[5]  = '{16'h0000, 1'b0, 16'h0040, 1'b0, 4'h0};
        tv[6]  = '{16'h0000, 1'b0, 16'h0040, 1'b0, 4'h0};
        tv[7]  = '{16'h0000, 1'b0, 16'h0040, 1'b0, 4'h0};
        tv[8]  = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[9]  = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[10] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[11] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[12] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[13] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[14] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[15] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 4'h0};
        tv[16] = '{16'h0020, 1'b0, 16'h0001, 1'b0, 4'h0};
        tv[17] = '{16'h0020, 1'b0, 16'h0001, 1'b0, 4'h0};
        tv[18] = '{16'h0020, 1'b0, 16'h0001, 1'b0, 4'h0};
        tv[19] = '{16'h0020, 1'b1, 16'h0020, 1'b0, 4'h0};
        tv[20] = '{16'h0000, 1'b1, 16'h0020, 1'b0, 4'h0};
        tv[21] = '{16'h0000, 1'b1, 16'h0020, 1'b0, 4'h0};
        tv[22] = '{16'h0000, 1'b1, 16'h0020, 1'b0, 4'h0};
        tv[23] = '{16'h0000, 1'b1, 16'h0000, 1'b1, 4'h5};
        tv[24] = '{16'h0000, 1'b1, 16'h0000, 1'b0, 4'h5};
        tv[25] = '{16'h0000, 1'b0, 16'h0000, 1'b0, 4'h5};
        tv[26] = '{16'h0088, 1'b0, 16'h0000, 1'b0, 4'h5};
        tv[27] = '{16'h0088, 1'b0, 16'h0000, 1'b0, 4'h5};
        tv[28] = '{16'h0088, 1'b1, 16'h0000, 1'b0, 4'h5};
        tv[29] = '{16'h0000, 1'b1, 16'h0088, 1'b0, 4'h5};
        tv[30] = '{16'h0000, 1'b1, 16'h0088, 1'b0, 4'h5};
        tv[31] = '{16'h0000, 1'b1, 16'h0088, 1'b0, 4'h5};
        tv[32] = '{16'h0000, 1'b0, 16'h0000, 1'b1, 4'h3};
        tv[33] = '{16'h0016, 1'b0, 16'h0000, 1'b0, 4'h3};
        tv[34] = '{16'h0016, 1'b0, 16'h0000, 1'b0, 4'h3};
        tv[35] = '{16'h0016, 1'b0, 16'h0000, 1'b0, 4'h3};
        tv[36] = '{16'h0016, 1'b0, GK,        1'b0, 4'h3};
        tv[37] = '{16'h0000, 1'b0, GK,        1'b0, 4'h3};

        pressed = '0;
        wait_req = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_col", {28'd0, col_n}, 32'hE);

        for (int j = 0; j < 38; j++) begin
            run_frame(tv[j].press, tv[j].wr);
            chk("tbl_keys", {16'd0, seen_keys}, {16'd0, tv[j].exp_keys});
            chk("tbl_valid", {31'd0, seen_valid}, {31'd0, tv[j].exp_valid});
            chk("tbl_wkey", {28'd0, seen_wkey}, {28'd0, tv[j].exp_wkey});
        end

        rp = '0;
        rw = 1'b0;
        for (int j = 0; j < 60; j++) begin
            if ($urandom_range(0, 3) == 0) begin
                rp = '0;
                for (int n = $urandom_range(0, 3); n > 0; n--) rp[$urandom_range(0, 15)] = 1'b1;
            end
            if ($urandom_range(0, 4) == 0) rw = ~rw;
            run_frame(rp, rw);
        end

        // Reset mid-frame while armed with a key held
        run_frame(16'h0200, 1'b0);
        for (int j = 0; j < 4; j++) run_frame(16'h0200, 1'b1);
        pressed = '0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk_reset_outputs("midreset_held");
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("restart_col", {28'd0, col_n}, 32'hE);
        for (int j = 0; j < 4; j++) run_frame(16'h0000, 1'b1);
        run_frame(16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the CHIP-8 4x4 hex keypad matrix and debounces each key.
- Presents a 16-bit key map indexed by hex value to the CPU, for EX9E/EXA1.
- Provides the FX0A wait-for-key handshake.
- Sits directly upstream of rng: any_key drives rng.user_input, so keypresses stir the generator.

Parameters:
- SETTLE_CYCLES, 4: cycles a column is driven before its rows are sampled; must be >=3 to cover the 2-flop row synchronizer.
- DEBOUNCE_FRAMES, 3: consecutive full-scan frames a key's raw value must differ from its stable value before the stable value flips; must be >=1.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- row_n, input, 4: matrix rows, active low, externally pulled up, asynchronous to clk.
- col_n, output, 4: matrix column drive, active low, one-hot-low while scanning.
- keys, output, 16: debounced key state; bit k=1 means hex key k is held.
- any_key, output, 1: OR of keys; connects to rng.user_input.
- wait_req, input, 1: level from CPU, held high while executing FX0A.
- wait_valid, output, 1: one-cycle pulse; wait_key is valid in that cycle.
- wait_key, output, 4: hex value of the key whose release completed the wait.

Behaviour:
- Reset (async, rst_n low):
  - col_n=4'b1111, keys=0, any_key=0, wait_valid=0, wait_key=0.
  - Synchronizers, debounce counters and raw frame cleared; scan FSM in column 0, settle count 0; wait FSM in W_IDLE.
- Reset is legal mid-frame or mid-wait. It discards all partial state; no wait_valid is produced for a wait in progress.
- Row input: row_n passes through a 2-flop synchronizer before any use.
- Scan:
  - Each column c (0..3) occupies SETTLE_CYCLES+1 cycles. col_n[c]=0 and the other columns are 1 for the whole slot.
  - In the slot's last cycle the synchronized rows are inverted and stored into raw[r][c].
  - Frame length = 4*(SETTLE_CYCLES+1) cycles; column 3 wraps to column 0 with no gap.
  - The first cycle after reset release drives col_n=4'b1110.
- Mapping from matrix (row, col) to hex value, COSMAC layout:
  - row0: 1 2 3 C
  - row1: 4 5 6 D
  - row2: 7 8 9 E
  - row3: A 0 B F
- Debounce, evaluated once per frame, in the cycle after column 3 is sampled:
  - Per key: if raw==stable, clear the counter.
  - Otherwise increment the counter. When it reaches DEBOUNCE_FRAMES, flip stable and clear the counter.
  - keys and any_key are registered and update in that same cycle.
- Wait FSM:
  - W_IDLE: when wait_req=1, go to W_ARMED.
  - W_ARMED: on a debounce update where at least one key flips 1->0 (release), pulse wait_valid. wait_key = lowest hex value among the released keys. Go to W_HOLD.
    - Keys already held at arming count only when they are released.
    - Presses do not complete the wait.
    - If wait_req drops while armed, return to W_IDLE with no pulse.
  - W_HOLD: wait_valid=0; stay until wait_req=0, then go to W_IDLE. This means one FX0A yields exactly one pulse.
- wait_key holds its value until the next wait_valid pulse.
- Simultaneous release of keys 3 and 7 in one frame: wait_key=3.

Optional Feature:
- Macro: KEYPAD_GHOST_REJECT_EN.
- Defined: any frame whose raw matrix contains more than 2 pressed keys is discarded. Debounce counters and stable state are left unchanged for that frame, which suppresses diode-less ghosting.
- Undefined: every frame is applied as sampled.

Decomposition:
- Package chip8_keypad_pkg holds:
  - KEY_MAP constant, a 4x4 array of 4-bit hex values.
  - Scan state enum.
  - Wait state enum (W_IDLE, W_ARMED, W_HOLD).
- Sub-module keypad_debounce: one key's counter and stable bit, with inputs frame_strobe and raw. Instantiated 16 times.

Test Plan (SETTLE_CYCLES=4, DEBOUNCE_FRAMES=3, frame=20 cycles):
- Reset release with no keys -> col_n cycles 1110,1101,1011,0111, each for 5 cycles; keys=0, any_key=0 throughout.
- Hold row1 low while col2 is driven (key 6), steady -> keys=16'h0040 and any_key=1 at the end of the 3rd full frame after the press is stable; release -> keys=0 three frames later.
- Key 0 (row3/col1) bounces, toggling every frame for 4 frames, then stays pressed -> keys[0] never asserts during the bounce; asserts 3 frames after it settles.
- wait_req=1 while key 5 is held, then key 5 is released -> no pulse at arming; a single wait_valid with wait_key=5 on the debounced release; no further pulse while wait_req stays high.
- rst_n low mid-frame while armed -> all outputs return to reset values immediately; no wait_valid; the scan restarts at col_n=4'b1110.
- KEYPAD_GHOST_REJECT_EN defined, keys 1, 2, 4 held -> keys stays 0. Undefined, same stimulus -> keys=16'h0016.
